// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier, signed or unsigned operands, one recoding step per clock.
// Define BOOTH_RADIX4_EN for radix-4 modified Booth (two bits per cycle); radix-2 otherwise.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   y,
    output logic [1:0]           dbg_state
);

    localparam int M    = WIDTH + 1;
`ifdef BOOTH_RADIX4_EN
    localparam int ITER = (M + 1) / 2;
    localparam int QW   = 2 * ITER;
    localparam int AW   = M + 2;
`else
    localparam int ITER = M;
    localparam int QW   = M;
    localparam int AW   = M + 1;
`endif
    localparam int SW   = AW + QW + 1;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshake: start is sampled only in IDLE or DONE; busy is high exactly while
    // in RUN, done is a single-cycle pulse in DONE, and y is stable until the next DONE.
    state_t                r_state;
    state_t                w_state_next;
    logic [AW-1:0]         r_acc;
    logic [QW-1:0]         r_q;
    logic                  r_q1;
    logic [AW-1:0]         r_mc;
    logic [CW-1:0]         r_cnt;
    logic [2*WIDTH-1:0]    r_y;

    logic [M-1:0]          w_a_ext;
    logic [M-1:0]          w_b_ext;
    logic [AW-1:0]         w_mc_in;
    logic [QW-1:0]         w_q_in;
    logic [SW-1:0]         w_step;
    logic                  w_last;

    function automatic logic [SW-1:0] booth_step(
        input logic [AW-1:0] acc,
        input logic [QW-1:0] q,
        input logic          q1,
        input logic [AW-1:0] mc
    );
        logic [AW-1:0]        sum;
        logic signed [SW-1:0] cat;
`ifdef BOOTH_RADIX4_EN
        case ({q[1:0], q1})
            3'b001, 3'b010: sum = acc + mc;
            3'b011:         sum = acc + (mc << 1);
            3'b100:         sum = acc - (mc << 1);
            3'b101, 3'b110: sum = acc - mc;
            default:        sum = acc;
        endcase
        cat = {sum, q, q1};
        return cat >>> 2;
`else
        case ({q[0], q1})
            2'b01:   sum = acc + mc;
            2'b10:   sum = acc - mc;
            default: sum = acc;
        endcase
        cat = {sum, q, q1};
        return cat >>> 1;
`endif
    endfunction

    // Unsigned operands get a zero top bit so the signed Booth datapath handles both modes.
    assign w_a_ext = {signed_mode & a[WIDTH-1], a};
    assign w_b_ext = {signed_mode & b[WIDTH-1], b};
    assign w_mc_in = AW'($signed(w_a_ext));
    assign w_q_in  = QW'($signed(w_b_ext));

    assign w_step  = booth_step(r_acc, r_q, r_q1, r_mc);
    assign w_last  = (r_cnt == CW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_q   <= '0;
            r_q1  <= 1'b0;
            r_mc  <= '0;
            r_cnt <= '0;
            r_y   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_acc <= '0;
                        r_q   <= w_q_in;
                        r_q1  <= 1'b0;
                        r_mc  <= w_mc_in;
                        r_cnt <= CW'(ITER);
                    end
                end
                S_RUN: begin
                    {r_acc, r_q, r_q1} <= w_step;
                    r_cnt              <= r_cnt - CW'(1);
                    // {acc, q} is the full signed product after the last shift.
                    if (w_last) r_y <= w_step[2*WIDTH:1];
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign y         = r_y;
    assign dbg_state = r_state;

endmodule
